// File: rtl/shared_divider.sv
// Round-robin shared restoring divider: one unsigned WIDTH-bit division per grant, WIDTH cycles ack-to-done.
// Requests are ignored while busy and are arbitrated on the next idle cycle; requesters hold req until ack.
module shared_divider #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] dividend,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS-1:0]       done,
    output logic [WIDTH-1:0]          quotient,
    output logic [WIDTH-1:0]          remainder,
    output logic                      div_zero,
    output logic                      busy
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = $clog2(WIDTH);

    typedef enum logic {IDLE, CALC} state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0]       r_rr, r_chan, w_grant;
    logic                w_any, w_capture, w_last;
    logic [NW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_dq, r_rem, r_dvs;
    logic [WIDTH-1:0]    w_sel_dvd, w_sel_dvs, w_rem_nxt, w_dq_nxt;
    logic [WIDTH:0]      w_trial, w_diff;
    logic                w_ge;
    logic [CHANNELS-1:0] r_ack, r_done;
    logic [WIDTH-1:0]    r_quo, r_remo;
    logic                r_dz, r_busy;

    // Two passes give a rotating priority: channels at or above rr first, then the wrap-around.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_any && req[i] && (CW'(i) >= r_rr)) begin
                w_any   = 1'b1;
                w_grant = CW'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_any && req[i]) begin
                w_any   = 1'b1;
                w_grant = CW'(i);
            end
        end
    end

    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == CW'(i)) begin
                w_sel_dvd = dividend[i*WIDTH +: WIDTH];
                w_sel_dvs = divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Partial remainder stays below the divisor (or below 2^k for a zero divisor), so the
    // top bit of trial-divisor is set exactly when the trial is smaller: it acts as the borrow.
    assign w_trial   = {r_rem, r_dq[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_dq_nxt  = {r_dq[WIDTH-2:0], w_ge};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr   <= '0;
            r_chan <= '0;
            r_cnt  <= '0;
            r_dq   <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_ack  <= '0;
            r_done <= '0;
            r_quo  <= '0;
            r_remo <= '0;
            r_dz   <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            if (w_capture) begin
                r_ack[w_grant] <= 1'b1;
                r_chan         <= w_grant;
                r_rr           <= (w_grant == CW'(CHANNELS-1)) ? '0 : w_grant + 1'b1;
                r_dq           <= w_sel_dvd;
                r_dvs          <= w_sel_dvs;
                r_rem          <= '0;
                r_cnt          <= NW'(WIDTH-1);
                r_busy         <= 1'b1;
            end else if (r_state == CALC) begin
                r_dq  <= w_dq_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_quo          <= w_dq_nxt;
                    r_remo         <= w_rem_nxt;
                    r_dz           <= (r_dvs == '0);
                    r_done[r_chan] <= 1'b1;
                    r_busy         <= 1'b0;
                end
            end
        end
    end

    assign ack       = r_ack;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_remo;
    assign div_zero  = r_dz;
    assign busy      = r_busy;

endmodule
